// File: rtl/gen_if_burst_accum.sv
// gen_if_burst_accum
// ------------------
// Sums bursts of exactly K unsigned W-bit samples taken over a valid/ready
// input. Each finished sum is offered on a valid/ready output port.
// K also picks the overflow arithmetic at elaboration time:
//   K > 12  : saturating sums. A sticky flag records any clamp in the burst.
//   K <= 12 : wrapping sums (mod 2^W). out_sat is always 0.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous burst abort, honoured only while accumulating
//   in_valid  : sample valid
//   in_ready  : sample ready (combinational: accumulating and not clearing)
//   in_data   : sample value
//   out_valid : burst result valid
//   out_ready : burst result ready
//   out_data  : burst sum, meaningful only while out_valid is high
//   out_sat   : saturation happened somewhere in this burst
//   count     : samples accepted so far in the current burst
module gen_if_burst_accum #(
    parameter int K = 11,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat,
    output logic [7:0]   count
);

    localparam logic [7:0] K_C = 8'(K);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [W-1:0]   acc_q,       acc_d;
    logic [7:0]     count_q,     count_d;
    logic           sticky_q,    sticky_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic           out_sat_q,   out_sat_d;

    logic [W-1:0]   sum_s;
    logic           clamp_s;
    logic           in_ready_s;
    logic           accept_s;
    logic [7:0]     count_inc_s;

    // The arithmetic mode is fixed per instance by K.
    if (K > 12) begin : g_sat
        logic [W:0] wide_s;

        // Saturating add: an extra carry bit detects overflow, which clamps to all ones.
        always_comb begin
            wide_s = {1'b0, acc_q} + {1'b0, in_data};
            if (wide_s[W]) begin
                sum_s   = {W{1'b1}};
                clamp_s = 1'b1;
            end else begin
                sum_s   = wide_s[W-1:0];
                clamp_s = 1'b0;
            end
        end
    end else begin : g_wrap
        // Wrapping add: the carry out is simply dropped.
        always_comb begin
            sum_s   = acc_q + in_data;
            clamp_s = 1'b0;
        end
    end

    // Handshake qualifiers for the input port.
    always_comb begin
        in_ready_s  = (state_q == ST_ACC) && !clear;
        accept_s    = in_valid && in_ready_s;
        count_inc_s = count_q + 8'd1;
    end

    // Next-state and datapath logic for the ACC/OUT burst machine.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (clear) begin
                    acc_d    = {W{1'b0}};
                    count_d  = 8'd0;
                    sticky_d = 1'b0;
                end else if (accept_s) begin
                    acc_d    = sum_s;
                    count_d  = count_inc_s;
                    sticky_d = sticky_q | clamp_s;
                    // The completing sample is folded into the result on this same edge.
                    if (count_inc_s == K_C) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = sum_s;
                        out_sat_d   = sticky_q | clamp_s;
                    end else begin
                        state_d     = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                // clear is deliberately ignored here so a finished burst is never lost.
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    acc_d       = {W{1'b0}};
                    count_d     = 8'd0;
                    sticky_d    = 1'b0;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_ACC;
                acc_d       = {W{1'b0}};
                count_d     = 8'd0;
                sticky_d    = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= {W{1'b0}};
            count_q     <= 8'd0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign count     = count_q;

endmodule

// File: tb/tb_gen_if_burst_accum.sv
// Bench for gen_if_burst_accum: one wrapping instance (K=11, prefix a_)
// and one saturating instance (K=13, prefix b_). A reference model per
// instance pushes each expected burst result into a scoreboard queue when
// the completing sample is driven; the entry is compared while the DUT holds
// out_valid and popped on the output handshake.
module tb_gen_if_burst_accum;

    logic        clk;
    logic        rst_n;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
    logic [31:0] a_in_data, a_out_data;
    logic [7:0]  a_count;
    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_count;

    int total = 0;
    int bad   = 0;
    int rdy_low_seen = 0;

    // reference model state, index 0 = K11 wrap, 1 = K13 saturate
    logic [31:0] m_acc [2];
    int          m_cnt [2];
    bit          m_sat [2];
    bit          m_out [2];
    logic [32:0] sbq0[$];
    logic [32:0] sbq1[$];

    gen_if_burst_accum #(.K(11), .W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_sat(a_out_sat), .count(a_count)
    );

    gen_if_burst_accum #(.K(13), .W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sat(b_out_sat), .count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int k_of(input int i);
        return (i == 0) ? 11 : 13;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 32'h0;
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
            m_out[i] = 1'b0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // Drives one clock of stimulus (called just after a negedge), checks
    // in_ready before the edge, advances the model on the edge and checks
    // the registered outputs at the following negedge.
    task automatic step(input int d, input bit v, input logic [31:0] dat,
                        input bit clr, input bit ordy, output bit took);
        bit          vv[2], cc[2], rr[2], exp_rdy, got_rdy, got_ov;
        logic [31:0] dd[2], got_data;
        logic [7:0]  got_cnt;
        logic [32:0] exp_e;
        logic        got_sat;
        longint      sum;
        took = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vv[i] = (i == d) ? v : 1'b0;
            dd[i] = (i == d) ? dat : 32'h0;
            cc[i] = (i == d) ? clr : 1'b0;
            rr[i] = (i == d) ? ordy : 1'b1;
        end
        a_in_valid = vv[0]; a_in_data = dd[0]; a_clear = cc[0]; a_out_ready = rr[0];
        b_in_valid = vv[1]; b_in_data = dd[1]; b_clear = cc[1]; b_out_ready = rr[1];
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_rdy = !m_out[i] && !cc[i];
            got_rdy = (i == 0) ? a_in_ready : b_in_ready;
            if (i == d && got_rdy == 1'b0) rdy_low_seen++;
            total++;
            if (got_rdy !== exp_rdy) begin
                bad++;
                $display("FAIL in_ready dut%0d got=%b exp=%b t=%0t", i, got_rdy, exp_rdy, $time);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_out[i]) begin
                if (cc[i]) begin
                    m_acc[i] = 32'h0; m_cnt[i] = 0; m_sat[i] = 1'b0;
                end else if (vv[i]) begin
                    if (i == d) took = 1'b1;
                    sum = longint'(m_acc[i]) + longint'(dd[i]);
                    if (i == 1 && sum > 64'sh0000_0000_FFFF_FFFF) begin
                        m_acc[i] = 32'hFFFF_FFFF;
                        m_sat[i] = 1'b1;
                    end else begin
                        m_acc[i] = 32'(sum);
                    end
                    m_cnt[i]++;
                    if (m_cnt[i] == k_of(i)) begin
                        m_out[i] = 1'b1;
                        if (i == 0) sbq0.push_back({m_sat[i], m_acc[i]});
                        else        sbq1.push_back({m_sat[i], m_acc[i]});
                    end
                end
            end else if (rr[i]) begin
                if (i == 0 && sbq0.size() > 0) void'(sbq0.pop_front());
                if (i == 1 && sbq1.size() > 0) void'(sbq1.pop_front());
                m_out[i] = 1'b0; m_acc[i] = 32'h0; m_cnt[i] = 0; m_sat[i] = 1'b0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            got_ov   = (i == 0) ? a_out_valid : b_out_valid;
            got_cnt  = (i == 0) ? a_count     : b_count;
            got_data = (i == 0) ? a_out_data  : b_out_data;
            got_sat  = (i == 0) ? a_out_sat   : b_out_sat;
            total++;
            if (got_ov !== m_out[i]) begin
                bad++;
                $display("FAIL out_valid dut%0d got=%b exp=%b t=%0t", i, got_ov, m_out[i], $time);
            end
            total++;
            if (got_cnt !== 8'(m_cnt[i])) begin
                bad++;
                $display("FAIL count dut%0d got=%0d exp=%0d t=%0t", i, got_cnt, m_cnt[i], $time);
            end
            if (m_out[i]) begin
                if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
                    total++; bad++;
                    $display("FAIL scoreboard_empty dut%0d t=%0t", i, $time);
                end else begin
                    exp_e = (i == 0) ? sbq0[0] : sbq1[0];
                    total++;
                    if ({got_sat, got_data} !== exp_e) begin
                        bad++;
                        $display("FAIL result dut%0d got sat=%b data=%h exp sat=%b data=%h t=%0t",
                                 i, got_sat, got_data, exp_e[32], exp_e[31:0], $time);
                    end
                end
            end
        end
    endtask

    // Offers a sample until the model says it was taken; bounded retries.
    task automatic feed_one(input int d, input logic [31:0] dat, input bit ordy);
        bit took;
        int tries;
        tries = 0;
        took  = 1'b0;
        while (!took && tries < 8) begin
            step(d, 1'b1, dat, 1'b0, ordy, took);
            tries++;
        end
        if (!took) begin
            total++; bad++;
            $display("FAIL accept_timeout dut%0d t=%0t", d, $time);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = 32'h0; a_clear = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 32'h0; b_clear = 1'b0; b_out_ready = 1'b1;
        model_reset();
        #1;
        total++;
        if ({a_out_valid, a_out_sat, a_count, a_out_data} !== 42'h0) begin
            bad++;
            $display("FAIL reset_a got ov=%b sat=%b cnt=%0d data=%h exp all zero",
                     a_out_valid, a_out_sat, a_count, a_out_data);
        end
        total++;
        if ({b_out_valid, b_out_sat, b_count, b_out_data} !== 42'h0) begin
            bad++;
            $display("FAIL reset_b got ov=%b sat=%b cnt=%0d data=%h exp all zero",
                     b_out_valid, b_out_sat, b_count, b_out_data);
        end
        total++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_in_ready got=%b%b exp=11", a_in_ready, b_in_ready);
        end
        b_clear = 1'b1;
        #1;
        total++;
        if (b_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_clear got=%b exp=0", b_in_ready);
        end
        b_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit took;
        rdy_low_seen = 0;
        for (int n = 1; n <= 11; n++) feed_one(0, 32'(n), 1'b1);
        total++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'd66 || a_out_sat !== 1'b0) begin
            bad++;
            $display("FAIL b2b_sum got ov=%b data=%0d sat=%b exp ov=1 data=66 sat=0",
                     a_out_valid, a_out_data, a_out_sat);
        end
        for (int n = 1; n <= 11; n++) feed_one(0, 32'(n), 1'b1);
        total++;
        if (rdy_low_seen !== 1) begin
            bad++;
            $display("FAIL b2b_bubble got=%0d exp=1", rdy_low_seen);
        end
        step(0, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic test_wrap();
        bit took;
        for (int n = 0; n < 11; n++) feed_one(0, 32'h2000_0000, 1'b1);
        total++;
        if (a_out_data !== 32'h6000_0000 || a_out_sat !== 1'b0) begin
            bad++;
            $display("FAIL wrap got data=%h sat=%b exp data=60000000 sat=0", a_out_data, a_out_sat);
        end
        step(0, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic test_saturate();
        bit took;
        for (int n = 0; n < 13; n++) feed_one(1, 32'h4000_0000, 1'b1);
        total++;
        if (b_out_data !== 32'hFFFF_FFFF || b_out_sat !== 1'b1) begin
            bad++;
            $display("FAIL sat_clamp got data=%h sat=%b exp data=ffffffff sat=1", b_out_data, b_out_sat);
        end
        for (int n = 0; n < 13; n++) feed_one(1, 32'h1, 1'b1);
        total++;
        if (b_out_data !== 32'd13 || b_out_sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_sticky_clear got data=%0d sat=%b exp data=13 sat=0", b_out_data, b_out_sat);
        end
        step(1, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic test_backpressure();
        bit          took;
        logic [31:0] held;
        for (int n = 0; n < 13; n++) feed_one(1, 32'(n * 5 + 1), 1'b0);
        held = b_out_data;
        for (int c = 0; c < 5; c++) begin
            step(1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, took);
            total++;
            if (b_out_valid !== 1'b1 || b_out_data !== held || b_count !== 8'd13) begin
                bad++;
                $display("FAIL backpressure got ov=%b data=%h cnt=%0d exp ov=1 data=%h cnt=13",
                         b_out_valid, b_out_data, b_count, held);
            end
        end
        total++;
        if (held !== 32'd403) begin
            bad++;
            $display("FAIL backpressure_sum got=%0d exp=403", held);
        end
        step(1, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic test_clear();
        bit took;
        for (int n = 0; n < 5; n++) feed_one(0, 32'd7, 1'b1);
        step(0, 1'b1, 32'd100, 1'b1, 1'b1, took);
        total++;
        if (a_count !== 8'd0) begin
            bad++;
            $display("FAIL clear_count got=%0d exp=0", a_count);
        end
        for (int n = 0; n < 11; n++) feed_one(0, 32'd2, 1'b1);
        total++;
        if (a_out_data !== 32'd22 || a_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL clear_sum got ov=%b data=%0d exp ov=1 data=22", a_out_valid, a_out_data);
        end
        // clear while a result is pending must not drop it
        step(0, 1'b0, 32'h0, 1'b1, 1'b0, took);
        step(0, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic test_async_reset();
        bit took;
        for (int n = 0; n < 6; n++) feed_one(1, 32'd3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (b_out_valid !== 1'b0 || b_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_burst got ov=%b cnt=%0d exp ov=0 cnt=0", b_out_valid, b_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 13; n++) feed_one(1, 32'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (b_out_valid !== 1'b0 || b_count !== 8'd0 || b_out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_in_out got ov=%b cnt=%0d data=%h exp ov=0 cnt=0 data=0",
                     b_out_valid, b_count, b_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 13; n++) feed_one(1, 32'd3, 1'b1);
        total++;
        if (b_out_data !== 32'd39 || b_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_recover got ov=%b data=%0d exp ov=1 data=39", b_out_valid, b_out_data);
        end
        step(1, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_saturate();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
